// File: rtl/lsu_pkg.sv
// Shared op/state encodings and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    function automatic logic is_store(lsu_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Offset bits that survive natural alignment for the access size.
    function automatic logic [1:0] align_mask(lsu_op_e op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2'b10;
            OP_LW, OP_SW:         return 2'b00;
            default:              return 2'b11;
        endcase
    endfunction

    function automatic logic is_misaligned(lsu_op_e op, logic [1:0] off);
        return (off & ~align_mask(op)) != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
// Handshake: req/resp transfer on a rising edge with valid and ready both high, payload held stable until then; mem_req holds until mem_gnt.
interface lsu_ctrl_if #(
    parameter int MEM_AW = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Combinational byte-lane steering: store enables/replicated data and extended load data.
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{off, 3'b000} +: 8];
    assign rhalf = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        be         = 4'b1111;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
        case (op)
            OP_SB: begin
                be         = 4'b0001 << off;
                wdata_lane = {4{wdata[7:0]}};
            end
            OP_SH: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            OP_SW:   wdata_lane = wdata;
            OP_LB:   rdata_ext  = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  rdata_ext  = {24'h0, rbyte};
            OP_LH:   rdata_ext  = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  rdata_ext  = {16'h0, rhalf};
            OP_LW:   rdata_ext  = rdata;
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Sequential load/store unit: one outstanding access, lane steering, window and timeout faults.
// Define LSU_MISALIGN_EXC_EN to fault misaligned accesses instead of force-aligning them.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int          MEM_AW   = 12,
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter int          TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus,
    output lsu_state_e dbg_state
);
    localparam int CW = 16;

    lsu_state_e    state;
    lsu_op_e       req_op, op_q, op_sel;
    logic [1:0]    acc_off, off_q, off_sel;
    logic [31:2]   rel_word;
    logic          out_of_range, fault;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata, lane_rdata;

    assign req_op       = lsu_op_e'(bus.req_op);
    // Base is window aligned, so the word-level subtraction equals the byte-level one.
    assign rel_word     = bus.req_addr[31:2] - MEM_BASE[31:2];
    assign out_of_range = |rel_word[31:MEM_AW];
    assign dbg_state    = state;

    always_comb begin
`ifdef LSU_MISALIGN_EXC_EN
        acc_off = bus.req_addr[1:0];
        fault   = out_of_range | is_misaligned(req_op, bus.req_addr[1:0]);
`else
        acc_off = bus.req_addr[1:0] & align_mask(req_op);
        fault   = out_of_range;
`endif
    end

    // Steering sees the live request while idle and the latched op afterwards.
    assign op_sel  = (state == ST_IDLE) ? req_op : op_q;
    assign off_sel = (state == ST_IDLE) ? acc_off : off_q;

    lsu_lane u_lane (
        .op         (op_sel),
        .off        (off_sel),
        .wdata      (bus.req_wdata),
        .rdata      (bus.mem_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_q           <= OP_LB;
            off_q          <= 2'b00;
            wait_cnt       <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= 4'h0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    op_q          <= req_op;
                    off_q         <= acc_off;
                    bus.req_ready <= 1'b0;
                    if (fault) begin
                        state          <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= 32'h0;
                    end else begin
                        state         <= ST_REQ;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= is_store(req_op);
                        bus.mem_be    <= lane_be;
                        bus.mem_addr  <= rel_word[MEM_AW-1:2];
                        bus.mem_wdata <= lane_wdata;
                    end
                end
                ST_REQ: if (bus.mem_gnt) begin
                    state       <= ST_WAIT;
                    bus.mem_req <= 1'b0;
                    wait_cnt    <= '0;
                end
                ST_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state          <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= lane_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (TIMEOUT != 0 && wait_cnt == CW'(TIMEOUT - 1)) begin
                            state          <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                        end
                    end
                end
                ST_RESP: if (bus.resp_ready) begin
                    state          <= ST_IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= 32'h0;
                    bus.req_ready  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed and randomized accesses checked every cycle against a transaction-level model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int          MEM_AW   = 12;
    localparam logic [31:0] MEM_BASE = 32'h0001_0000;
    localparam int          TIMEOUT  = 8;
    localparam int          NWORDS   = 1 << (MEM_AW - 2);
    localparam int          PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_RESP = 3;

    typedef struct {
        bit          fault;
        bit          store;
        int unsigned widx;
        int unsigned off;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    lsu_state_e dbg_state;

    always #5 clk = ~clk;

    lsu_ctrl_if #(.MEM_AW(MEM_AW)) bus ();

    lsu_ctrl #(.MEM_AW(MEM_AW), .MEM_BASE(MEM_BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- model state / scoreboard ----------------
    int                checks = 0;
    int                errors = 0;
    int                ph     = PH_IDLE;
    bit                mon_en = 1'b0;
    logic [32:0]       exp_q[$];
    logic              exp_we;
    logic [3:0]        exp_be;
    logic [31:0]       exp_wdata;
    logic [MEM_AW-3:0] exp_maddr;
    logic [31:0]       mem_m [NWORDS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          sz;
        logic [31:0] a;
        bit          oor, mis;
        sz  = op_size(op);
        oor = (addr - MEM_BASE) >= (32'd1 << MEM_AW);
        mis = (addr % 32'(sz)) != 0;
        a   = addr;
`ifdef LSU_MISALIGN_EXC_EN
        e.fault = oor || mis;
`else
        e.fault = oor;
        a       = addr - (addr % 32'(sz));
`endif
        e.store = op >= 3'd5;
        e.widx  = ((a - MEM_BASE) >> 2) % NWORDS;
        e.off   = a % 4;
        e.be    = e.store ? 4'(((32'd1 << sz) - 32'd1) << e.off) : 4'hF;
        case (sz)
            1:       e.wd = wdata[7:0] * 32'h0101_0101;
            2:       e.wd = wdata[15:0] * 32'h0001_0001;
            default: e.wd = wdata;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] op, input int unsigned off, input logic [31:0] word);
        longint unsigned v, m;
        int              sz;
        sz = op_size(op);
        m  = (64'd1 << (8 * sz)) - 64'd1;
        v  = (64'(word) >> (8 * off)) & m;
        if ((op == 3'd0 || op == 3'd1) && ((v >> (8 * sz - 1)) & 64'd1) == 64'd1) v = v | ~m;
        return v[31:0];
    endfunction

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("req_ready", 32'(bus.req_ready), 32'(ph == PH_IDLE));
            chk("mem_req", 32'(bus.mem_req), 32'(ph == PH_REQ));
            chk("resp_valid", 32'(bus.resp_valid), 32'(ph == PH_RESP));
            if (ph == PH_REQ) begin
                chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
                chk("mem_be", 32'(bus.mem_be), 32'(exp_be));
                chk("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
                if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
            end
            if (ph == PH_RESP && exp_q.size() != 0) begin
                chk("resp_err", 32'(bus.resp_err), 32'(exp_q[0][32]));
                chk("resp_rdata", bus.resp_rdata, exp_q[0][31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_dly, input int rv_dly, input int rdy_dly, input bit withhold);
        exp_t        e;
        logic [31:0] rd;
        bit          to;
        e  = model(op, addr, wdata);
        to = withhold && !e.fault && TIMEOUT != 0;
        rd = (e.fault || e.store || to) ? 32'h0 : load_val(op, e.off, mem_m[e.widx]);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        exp_q.push_back({e.fault || to, rd});
        if (e.fault) begin
            ph = PH_RESP;
        end else begin
            exp_we    = e.store;
            exp_be    = e.be;
            exp_wdata = e.wd;
            exp_maddr = (MEM_AW - 2)'(e.widx);
            ph        = PH_REQ;
            repeat (gnt_dly) begin @(posedge clk); #1; end
            bus.mem_gnt = 1'b1;
            @(posedge clk); #1;
            bus.mem_gnt = 1'b0;
            ph          = PH_WAIT;
            if (to) begin
                repeat (TIMEOUT) begin @(posedge clk); #1; end
            end else begin
                repeat (rv_dly - 1) begin @(posedge clk); #1; end
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = e.store ? $urandom : mem_m[e.widx];
                @(posedge clk); #1;
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
                if (e.store)
                    for (int b = 0; b < 4; b++)
                        if (e.be[b]) mem_m[e.widx][8*b +: 8] = e.wd[8*b +: 8];
            end
            ph = PH_RESP;
        end
        repeat (rdy_dly) begin
            bus.req_valid = 1'b1;
            if (withhold) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = $urandom;
            end
            @(posedge clk); #1;
        end
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        void'(exp_q.pop_front());
        ph = PH_IDLE;
    endtask

    task automatic reset_mid(input bit in_wait);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd2;
        bus.req_addr  = MEM_BASE + 32'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        exp_we        = 1'b0;
        exp_be        = 4'hF;
        exp_maddr     = (MEM_AW - 2)'(4);
        exp_q.push_back({1'b0, mem_m[4]});
        ph            = PH_REQ;
        if (in_wait) begin
            bus.mem_gnt = 1'b1;
            @(posedge clk); #1;
            bus.mem_gnt = 1'b0;
            ph          = PH_WAIT;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        ph = PH_IDLE;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t        e;
        logic [31:0] addr;
        int          sel;

        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        for (int i = 0; i < NWORDS; i++) mem_m[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // SB into the top lane of word 0x40
        e = model(3'd5, MEM_BASE + 32'h103, 32'h0000_00A5);
        chk("pin_sb_be", 32'(e.be), 32'h8);
        chk("pin_sb_wdata", e.wd, 32'hA5A5_A5A5);
        chk("pin_sb_addr", e.widx, 32'h40);
        chk("pin_sb_fault", 32'(e.fault), 32'd0);
        run_txn(3'd5, MEM_BASE + 32'h103, 32'h0000_00A5, 0, 1, 0, 1'b0);

        // sign/zero extension at offset 2
        mem_m[32'h80] = 32'h1280_FF34;
        chk("pin_lb", load_val(3'd0, 2, mem_m[32'h80]), 32'hFFFF_FF80);
        chk("pin_lbu", load_val(3'd3, 2, mem_m[32'h80]), 32'h0000_0080);
        chk("pin_lhu", load_val(3'd4, 2, mem_m[32'h80]), 32'h0000_1280);
        run_txn(3'd0, MEM_BASE + 32'h202, 32'h0, 0, 1, 0, 1'b0);
        run_txn(3'd3, MEM_BASE + 32'h202, 32'h0, 1, 2, 1, 1'b0);
        run_txn(3'd4, MEM_BASE + 32'h202, 32'h0, 0, 1, 0, 1'b0);

        // slow grant, slow data, slow consumer
        mem_m[32'h30] = 32'hDEAD_BEEF;
        chk("pin_lw", load_val(3'd2, 0, mem_m[32'h30]), 32'hDEAD_BEEF);
        run_txn(3'd2, MEM_BASE + 32'h0C0, 32'h0, 3, 5, 4, 1'b0);

        // first byte past the window
        e = model(3'd2, MEM_BASE + 32'h1000, 32'h0);
        chk("pin_oor_fault", 32'(e.fault), 32'd1);
        run_txn(3'd2, MEM_BASE + 32'h1000, 32'h0, 0, 1, 2, 1'b0);

        // timeout, stale rvalid in RESP and IDLE, then a clean load
        run_txn(3'd2, MEM_BASE + 32'h044, 32'h0, 1, 0, 2, 1'b1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        run_txn(3'd2, MEM_BASE + 32'h044, 32'h0, 0, 1, 0, 1'b0);

        // misaligned halfword store
        e = model(3'd6, MEM_BASE + 32'h021, 32'h1234_BEEF);
`ifdef LSU_MISALIGN_EXC_EN
        chk("pin_sh_fault", 32'(e.fault), 32'd1);
`else
        chk("pin_sh_be", 32'(e.be), 32'h3);
        chk("pin_sh_fault", 32'(e.fault), 32'd0);
`endif
        run_txn(3'd6, MEM_BASE + 32'h021, 32'h1234_BEEF, 0, 1, 1, 1'b0);

        // reset in REQ and in WAIT, then recovery
        reset_mid(1'b0);
        reset_mid(1'b1);
        run_txn(3'd2, MEM_BASE + 32'h010, 32'h0, 0, 1, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = MEM_BASE + 32'h1000 + $urandom_range(0, 8000);
            else if (sel == 1) addr = MEM_BASE - $urandom_range(1, 64);
            else               addr = MEM_BASE + $urandom_range(0, 4095);
            run_txn(3'($urandom_range(0, 7)), addr, $urandom, $urandom_range(0, 3),
                    $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
